// File: rtl/vx_warp_ibuffer_pkg.sv
// Shared decoded-instruction payload layout for the issue buffer and scoreboard.
package vx_warp_ibuffer_pkg;

    localparam int UUID_W    = 6;
    localparam int TMASK_W   = 4;
    localparam int PC_W      = 20;
    localparam int EX_TYPE_W = 2;
    localparam int OP_TYPE_W = 4;
    localparam int OP_ARGS_W = 3;
    localparam int REG_W     = 6;

    typedef struct packed {
        logic [UUID_W-1:0]    uuid;
        logic [TMASK_W-1:0]   tmask;
        logic [PC_W-1:0]      pc;
        logic [EX_TYPE_W-1:0] ex_type;
        logic [OP_TYPE_W-1:0] op_type;
        logic [OP_ARGS_W-1:0] op_args;
        logic                 wb;
        logic [REG_W-1:0]     rd;
        logic [REG_W-1:0]     rs1;
        logic [REG_W-1:0]     rs2;
        logic [REG_W-1:0]     rs3;
    } ibuf_payload_t;

    localparam int IBUF_DATAW = $bits(ibuf_payload_t);

endpackage

// File: rtl/vx_warp_ibuffer_if.sv
// Decode-side push bus and per-warp head/status bus of the warp instruction buffer.
interface vx_warp_ibuffer_if
    import vx_warp_ibuffer_pkg::*;
#(
    parameter int NUM_WARPS = 4,
    parameter int DATAW     = IBUF_DATAW
);
    localparam int WIDW = $clog2(NUM_WARPS);

    logic                                decode_valid;
    logic [WIDW-1:0]                     decode_wid;
    logic [DATAW-1:0]                    decode_data;
    logic                                decode_ready;
    logic [NUM_WARPS-1:0]                ibuf_valid;
    logic [NUM_WARPS-1:0][DATAW-1:0]     ibuf_data;
    logic [NUM_WARPS-1:0]                ibuf_ready;
    logic [NUM_WARPS-1:0]                warp_full;
    logic [NUM_WARPS-1:0]                warp_empty;

    modport master (
        output decode_valid, decode_wid, decode_data, ibuf_ready,
        input  decode_ready, ibuf_valid, ibuf_data, warp_full, warp_empty
    );

    modport slave (
        input  decode_valid, decode_wid, decode_data, ibuf_ready,
        output decode_ready, ibuf_valid, ibuf_data, warp_full, warp_empty
    );

endinterface

// File: rtl/vx_warp_ibuffer_fifo.sv
// Single-warp circular FIFO with occupancy count; head is read straight from storage.
module vx_warp_ibuffer_fifo #(
    parameter int DEPTH = 4,
    parameter int DATAW = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [DATAW-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [DATAW-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    logic [DATAW-1:0] r_mem [DEPTH];
    logic [PTRW-1:0]  r_rd_ptr;
    logic [PTRW-1:0]  r_wr_ptr;
    logic [CNTW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNTW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_valid = ~o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // Full blocks a push even when a pop happens in the same cycle.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & o_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage has no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (r_count <= CNTW'(DEPTH))
            else $error("ibuf fifo occupancy %0d exceeds depth %0d", r_count, DEPTH);
        end
    end

endmodule

// File: rtl/vx_warp_ibuffer.sv
// Per-warp instruction buffer: routes decoded instructions into one FIFO per warp.
module vx_warp_ibuffer
    import vx_warp_ibuffer_pkg::*;
#(
    parameter int NUM_WARPS = 4,
    parameter int DEPTH     = 4,
    parameter int DATAW     = IBUF_DATAW
) (
    input  logic                    clk,
    input  logic                    reset,
    vx_warp_ibuffer_if.slave        ibuf_if
);
    localparam int WIDW = $clog2(NUM_WARPS);

    logic [NUM_WARPS-1:0]            w_push;
    logic [NUM_WARPS-1:0]            w_valid;
    logic [NUM_WARPS-1:0]            w_full;
    logic [NUM_WARPS-1:0]            w_empty;
    logic [NUM_WARPS-1:0][DATAW-1:0] w_data;
    logic                            w_decode_ready;

    assign w_decode_ready      = ~w_full[ibuf_if.decode_wid];
    assign ibuf_if.decode_ready = w_decode_ready;
    assign ibuf_if.ibuf_valid   = w_valid;
    assign ibuf_if.ibuf_data    = w_data;
    assign ibuf_if.warp_full    = w_full;
    assign ibuf_if.warp_empty   = w_empty;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        assign w_push[w] = ibuf_if.decode_valid & w_decode_ready &
                           (ibuf_if.decode_wid == WIDW'(w));

        vx_warp_ibuffer_fifo #(
            .DEPTH (DEPTH),
            .DATAW (DATAW)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_push  (w_push[w]),
            .i_data  (ibuf_if.decode_data),
            .i_pop   (ibuf_if.ibuf_ready[w]),
            .o_valid (w_valid[w]),
            .o_data  (w_data[w]),
            .o_full  (w_full[w]),
            .o_empty (w_empty[w])
        );
    end

endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// Directed bench for vx_warp_ibuffer with a queue model for the interleaved phase.
module tb_vx_warp_ibuffer;
    localparam int NW = 4;
    localparam int D  = 4;
    localparam int DW = 64;

    logic clk;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    logic [63:0] mq [NW][$];

    vx_warp_ibuffer_if #(.NUM_WARPS(NW), .DATAW(DW)) bus ();

    vx_warp_ibuffer #(
        .NUM_WARPS (NW),
        .DEPTH     (D),
        .DATAW     (DW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ibuf_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input int wid, input logic [63:0] data);
        bus.decode_valid = 1'b1;
        bus.decode_wid   = 2'(wid);
        bus.decode_data  = data;
        tick();
        bus.decode_valid = 1'b0;
    endtask

    task automatic pop_chk(input int w, input logic [63:0] exp, input string tag);
        chk({tag, "_valid"}, 64'(bus.ibuf_valid[w]), 64'd1);
        chk({tag, "_data"}, bus.ibuf_data[w], exp);
        bus.ibuf_ready = 4'(1 << w);
        tick();
        bus.ibuf_ready = '0;
    endtask

    initial begin
        logic [3:0] rdy;
        logic       acc;
        int         wid;

        // Reset with a push presented: it must be dropped.
        reset            = 1'b1;
        bus.decode_valid = 1'b1;
        bus.decode_wid   = 2'd0;
        bus.decode_data  = 64'hDEAD;
        bus.ibuf_ready   = '0;
        tick();
        tick();
        reset            = 1'b0;
        bus.decode_valid = 1'b0;
        #1;
        chk("rst_valid", 64'(bus.ibuf_valid), 64'h0);
        chk("rst_empty", 64'(bus.warp_empty), 64'hF);
        chk("rst_full", 64'(bus.warp_full), 64'h0);
        chk("rst_ready", 64'(bus.decode_ready), 64'd1);

        // Single entry, no same-cycle bypass.
        bus.decode_valid = 1'b1;
        bus.decode_wid   = 2'd2;
        bus.decode_data  = 64'hA5;
        #1;
        chk("one_nobypass", 64'(bus.ibuf_valid[2]), 64'd0);
        tick();
        bus.decode_valid = 1'b0;
        chk("one_empty_n", 64'(bus.warp_empty[2]), 64'd0);
        pop_chk(2, 64'hA5, "one_pop");
        chk("one_empty", 64'(bus.warp_empty[2]), 64'd1);

        // Fill warp 1, reject extra push, drain in order.
        for (int i = 0; i < 4; i++) push_one(1, 64'h10 + 64'(i));
        chk("fill_full", 64'(bus.warp_full[1]), 64'd1);
        bus.decode_wid = 2'd1;
        #1;
        chk("fill_rdy_w1", 64'(bus.decode_ready), 64'd0);
        bus.decode_wid = 2'd0;
        #1;
        chk("fill_rdy_w0", 64'(bus.decode_ready), 64'd1);
        push_one(1, 64'hFF);
        chk("fill_still_full", 64'(bus.warp_full[1]), 64'd1);
        for (int i = 0; i < 4; i++) pop_chk(1, 64'h10 + 64'(i), "fill_pop");
        chk("fill_empty", 64'(bus.warp_empty[1]), 64'd1);

        // Full warp 0 with simultaneous pop and push: push rejected.
        for (int i = 0; i < 4; i++) push_one(0, 64'h20 + 64'(i));
        bus.decode_valid = 1'b1;
        bus.decode_wid   = 2'd0;
        bus.decode_data  = 64'h24;
        bus.ibuf_ready   = 4'b0001;
        #1;
        chk("fp_rdy_low", 64'(bus.decode_ready), 64'd0);
        tick();
        bus.ibuf_ready = '0;
        chk("fp_not_full", 64'(bus.warp_full[0]), 64'd0);
        chk("fp_head", bus.ibuf_data[0], 64'h21);
        chk("fp_rdy_high", 64'(bus.decode_ready), 64'd1);
        tick();
        bus.decode_valid = 1'b0;
        chk("fp_full_again", 64'(bus.warp_full[0]), 64'd1);
        for (int i = 1; i < 5; i++) pop_chk(0, 64'h20 + 64'(i), "fp_pop");

        // Wrap-around on warp 3: push/pop pairs keep occupancy at one.
        push_one(3, 64'd0);
        for (int i = 1; i < 10; i++) begin
            bus.decode_valid = 1'b1;
            bus.decode_wid   = 2'd3;
            bus.decode_data  = 64'(i);
            bus.ibuf_ready   = 4'b1000;
            #1;
            chk("wrap_data", bus.ibuf_data[3], 64'(i - 1));
            chk("wrap_notfull", 64'(bus.warp_full[3]), 64'd0);
            tick();
        end
        bus.decode_valid = 1'b0;
        bus.ibuf_ready   = '0;
        pop_chk(3, 64'd9, "wrap_last");
        chk("wrap_empty", 64'(bus.warp_empty[3]), 64'd1);

        // Interleaved pushes across warps with sparse random pops.
        for (int i = 0; i < 48; i++) begin
            wid              = i % NW;
            rdy              = 4'($urandom & $urandom & $urandom);
            bus.decode_valid = 1'b1;
            bus.decode_wid   = 2'(wid);
            bus.decode_data  = 64'h1000 + 64'(i);
            bus.ibuf_ready   = rdy;
            #1;
            acc = (mq[wid].size() < D);
            chk("il_ready", 64'(bus.decode_ready), 64'(acc));
            for (int w = 0; w < NW; w++) begin
                chk("il_valid", 64'(bus.ibuf_valid[w]), 64'(mq[w].size() != 0));
                if (rdy[w] && mq[w].size() != 0) begin
                    chk("il_data", bus.ibuf_data[w], mq[w][0]);
                    void'(mq[w].pop_front());
                end
            end
            if (acc) mq[wid].push_back(64'h1000 + 64'(i));
            tick();
        end
        bus.decode_valid = 1'b0;
        bus.ibuf_ready   = '1;
        for (int c = 0; c < D + 1; c++) begin
            for (int w = 0; w < NW; w++) begin
                chk("drain_valid", 64'(bus.ibuf_valid[w]), 64'(mq[w].size() != 0));
                if (mq[w].size() != 0) begin
                    chk("drain_data", bus.ibuf_data[w], mq[w][0]);
                    void'(mq[w].pop_front());
                end
            end
            tick();
        end
        bus.ibuf_ready = '0;
        chk("drain_empty", 64'(bus.warp_empty), 64'hF);

        // Mid-run reset discards queued entries.
        for (int i = 0; i < 3; i++) begin
            push_one(0, 64'h30 + 64'(i));
            push_one(2, 64'h40 + 64'(i));
        end
        chk("mr_valid_pre", 64'(bus.ibuf_valid), 64'h5);
        chk("mr_head2_pre", bus.ibuf_data[2], 64'h40);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mr_valid", 64'(bus.ibuf_valid), 64'h0);
        chk("mr_empty", 64'(bus.warp_empty), 64'hF);
        chk("mr_full", 64'(bus.warp_full), 64'h0);
        chk("mr_ready", 64'(bus.decode_ready), 64'd1);
        push_one(0, 64'h55);
        pop_chk(0, 64'h55, "mr_pop");
        chk("mr_empty_after", 64'(bus.warp_empty[0]), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vx_warp_ibuffer.md
VX_WARP_IBUFFER -- requirements
Module: VX_warp_ibuffer

Interface
REQ-001 Parameter NUM_WARPS, default 4: warps served by this issue slice; power of two, at least 2.
REQ-002 Parameter DEPTH, default 4: entries per warp queue; power of two, at least 2.
REQ-003 Parameter DATAW, default 64: decoded-instruction payload width.
REQ-004 clk  in  1  clock.
REQ-005 reset  in  1  reset: synchronous, active-high.
REQ-006 decode_valid  in  1  decoded instruction available.
REQ-007 decode_wid  in  log2(NUM_WARPS)  target warp of the instruction.
REQ-008 decode_data  in  DATAW  instruction payload.
REQ-009 decode_ready  out  1  instruction accepted this cycle.
REQ-010 ibuf_valid  out  NUM_WARPS  per-warp head entry valid.
REQ-011 ibuf_data  out  NUM_WARPS x DATAW  per-warp head payload.
REQ-012 ibuf_ready  in  NUM_WARPS  per-warp head consumed by the downstream scoreboard.
REQ-013 warp_full  out  NUM_WARPS  per-warp queue holds DEPTH entries; used by the scheduler to stop fetching that warp.
REQ-014 warp_empty  out  NUM_WARPS  per-warp queue holds 0 entries.

Function
REQ-015 Each warp has an independent FIFO with a read pointer, a write pointer (log2(DEPTH) bits, wrapping modulo DEPTH) and an occupancy counter (log2(DEPTH)+1 bits).
REQ-016 decode_ready = ~warp_full[decode_wid], combinational; a push occurs when decode_valid && decode_ready.
REQ-017 A push writes decode_data at the write pointer of decode_wid, then increments that pointer; no other warp changes.
REQ-018 A pop on warp w occurs when ibuf_valid[w] && ibuf_ready[w]; it advances that warp's read pointer.
REQ-019 ibuf_valid[w] = (count[w] != 0), ibuf_data[w] = head entry; both driven from registers or storage with no combinational path from decode_*.
REQ-020 Latency: a push into an empty queue in cycle N makes ibuf_valid high in cycle N+1; there is no same-cycle bypass.
REQ-021 Simultaneous push and pop on the same warp, with that warp not full, leaves the count unchanged and advances both pointers.
REQ-022 Full warp: decode_ready is low for that wid even if a pop occurs in the same cycle; there is no full-pop bypass.
REQ-023 A pop with ibuf_valid low is ignored; the count never underflows.
REQ-024 Pushes and pops on different warps in the same cycle are fully independent.
REQ-025 Entries of each warp leave in strict FIFO order across any number of pointer wrap-arounds.
REQ-026 The count stays at or below DEPTH at all times; in simulation, a violation fires an assertion.

Reset
REQ-027 On reset, all pointers and counts clear to 0, so ibuf_valid = 0, warp_empty = all ones, warp_full = 0 and decode_ready = 1 starting the cycle after reset.
REQ-028 Reset asserted mid-operation discards all queued entries; payload storage is not cleared.
REQ-029 decode_ready may be high during reset; pushes during reset are dropped.

Structure
REQ-030 The payload field layout (uuid, tmask, PC, ex_type, op_type, op_args, wb, rd, rs1, rs2, rs3) and its total width belong in VX_gpu_pkg, shared with the scoreboard.
REQ-031 One sub-module, VX_ibuf_fifo (a single-warp circular FIFO with count, full and empty), is instantiated NUM_WARPS times in a generate loop.
REQ-032 Target size is 150–250 lines of RTL.

Verification
REQ-033 Single entry: push wid=2 with data 0xA5 in cycle 0 -> ibuf_valid[2]=1 and ibuf_data[2]=0xA5 in cycle 1; pop it -> warp_empty[2]=1 in cycle 2.
REQ-034 Fill warp 1: push 4 entries 0x10..0x13 with no pop -> warp_full[1]=1 and decode_ready=0 while decode_wid=1, decode_ready=1 while decode_wid=0; pops return 0x10..0x13 in order.
REQ-035 Full plus pop: warp 0 full, pop and push with wid=0 in the same cycle -> push rejected and count=3; next cycle the push is accepted and count=4.
REQ-036 Wrap-around: 10 push/pop pairs with data 0..9 on warp 3 and DEPTH=4 -> outputs are 0..9 in order and the count never exceeds 1.
REQ-037 Interleave: pushes alternate across wids 0..3 while random ibuf_ready is applied -> a per-warp scoreboard model matches with no loss or reorder.
REQ-038 Mid-run reset: with warps 0 and 2 holding 3 entries each, assert reset for 1 cycle -> all ibuf_valid=0 and warp_empty=4'b1111 in the next cycle.
